// File: rtl/clock_cal_pkg.sv
// clock_cal_pkg: shared calendar constants and helpers for the clock/calendar chain
package clock_cal_pkg;

    localparam int MONTH_FEB      = 2;
    localparam int DAY_MIN        = 1;
    localparam int DAY_W          = 5;
    localparam int YEAR_W_DEFAULT = 14;

    // April, June, September and November are the only 30-day months
    function automatic logic is_30_day(input logic [3:0] m);
        return (m == 4'd4) || (m == 4'd6) || (m == 4'd9) || (m == 4'd11);
    endfunction

endpackage

// File: rtl/month_length.sv
// month_length: number of days in the given month of the given year (Gregorian)
module month_length
    import clock_cal_pkg::*;
#(
    parameter int YEAR_W = YEAR_W_DEFAULT
) (
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  max_day
);

    logic leap;

    // Leap when divisible by 4, except centuries not divisible by 400; illegal months read as 31
    always_comb begin
        leap    = (year[1:0] == 2'b00) &&
                  (((year % YEAR_W'(100)) != '0) || ((year % YEAR_W'(400)) == '0));
        max_day = (month == 4'(MONTH_FEB)) ? (leap ? DAY_W'(29) : DAY_W'(28)) :
                  is_30_day(month)         ? DAY_W'(30) : DAY_W'(31);
    end

endmodule

// File: rtl/day_counter.sv
// day_counter: day-of-month register with carry to the month counter, manual set and clamping
module day_counter
    import clock_cal_pkg::*;
#(
    parameter int YEAR_W = YEAR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up,
    input  logic              down,
    input  logic              signal,
    input  logic              manual_set,
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  day,
    output logic              signal_out
);

    localparam logic [DAY_W-1:0] FIRST = DAY_W'(DAY_MIN);

    logic [DAY_W-1:0] max_day;

    month_length #(.YEAR_W(YEAR_W)) u_month_length (
        .month   (month),
        .year    (year),
        .max_day (max_day)
    );

    // Manual up beats down beats carry; when idle, pull the day back inside a shortened month
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day        <= FIRST;
            signal_out <= 1'b0;
        end else begin
            signal_out <= 1'b0;
            if (manual_set && up)
                day <= (day >= max_day) ? FIRST : day + 1'b1;
            else if (manual_set && down)
                day <= (day <= FIRST) ? max_day : (day > max_day) ? max_day : day - 1'b1;
            else if (!manual_set && signal) begin
                if (day >= max_day) begin
                    day        <= FIRST;
                    signal_out <= 1'b1;
                end else begin
                    day <= day + 1'b1;
                end
            end else if (day > max_day)
                day <= max_day;
        end
    end

endmodule

// File: tb/tb_day_counter.sv
// tb_day_counter: directed vectors for day_counter with hand-computed expected values
module tb_day_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic        signal = 1'b0;
    logic        manual_set = 1'b0;
    logic [3:0]  month = 4'd1;
    logic [13:0] year = 14'd2024;
    logic [4:0]  day;
    logic        signal_out;

    int n_checks = 0;
    int n_fail   = 0;

    day_counter #(.YEAR_W(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up         (up),
        .down       (down),
        .signal     (signal),
        .manual_set (manual_set),
        .month      (month),
        .year       (year),
        .day        (day),
        .signal_out (signal_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        signal = 1'b1;
        tick();
        signal = 1'b0;
    endtask

    task automatic man(input logic u, input logic d);
        manual_set = 1'b1;
        up = u;
        down = d;
        tick();
        manual_set = 1'b0;
        up = 1'b0;
        down = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_day", day, 1);
        check("rst_so", signal_out, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_day", day, 1);
            check("idle_so", signal_out, 0);
        end

        // Jan 2023: wrap from 31 with one-cycle carry
        year = 14'd2023;
        man(1'b0, 1'b1);
        check("jan_set31", day, 31);
        pulse();
        check("jan_wrap_day", day, 1);
        check("jan_wrap_so", signal_out, 1);
        tick();
        check("jan_so_drop", signal_out, 0);
        check("jan_hold", day, 1);

        // Feb 2024 leap
        month = 4'd2;
        year = 14'd2024;
        man(1'b0, 1'b1);
        check("feb24_down", day, 29);
        man(1'b0, 1'b1);
        check("feb24_28", day, 28);
        pulse();
        check("feb24_29", day, 29);
        check("feb24_29_so", signal_out, 0);
        pulse();
        check("feb24_wrap", day, 1);
        check("feb24_wrap_so", signal_out, 1);
        tick();
        check("feb24_so_drop", signal_out, 0);

        // Feb 1900 not leap
        year = 14'd1900;
        man(1'b0, 1'b1);
        check("feb1900_28", day, 28);
        pulse();
        check("feb1900_wrap", day, 1);
        check("feb1900_so", signal_out, 1);

        // Feb 2000 leap
        year = 14'd2000;
        man(1'b0, 1'b1);
        check("feb2000_down", day, 29);
        man(1'b0, 1'b1);
        pulse();
        check("feb2000_29", day, 29);
        check("feb2000_so", signal_out, 0);

        // April manual mode: 29 -> 30 -> 1
        month = 4'd4;
        man(1'b1, 1'b0);
        check("apr_up30", day, 30);
        man(1'b1, 1'b0);
        check("apr_up_wrap", day, 1);
        man(1'b0, 1'b1);
        check("apr_down", day, 30);
        man(1'b1, 1'b0);
        check("apr_up", day, 1);
        man(1'b1, 1'b1);
        check("apr_up_wins", day, 2);
        manual_set = 1'b1;
        signal = 1'b1;
        tick();
        check("man_sig_day", day, 2);
        check("man_sig_so", signal_out, 0);
        tick();
        check("man_sig_day2", day, 2);
        check("man_sig_so2", signal_out, 0);
        manual_set = 1'b0;
        signal = 1'b0;

        // Illegal month reads as 31 days
        month = 4'd13;
        man(1'b0, 1'b1);
        man(1'b0, 1'b1);
        check("ill13_down", day, 31);
        month = 4'd0;
        man(1'b1, 1'b0);
        check("ill0_up_wrap", day, 1);

        // Clamp when month shortens under the day
        month = 4'd1;
        man(1'b0, 1'b1);
        check("clamp_set31", day, 31);
        month = 4'd2;
        year = 14'd2023;
        tick();
        check("clamp_day", day, 28);
        check("clamp_so", signal_out, 0);
        tick();
        check("clamp_hold", day, 28);

        // Async reset while carry is high
        pulse();
        check("pre_rst_so", signal_out, 1);
        rst_n = 1'b0;
        #2;
        check("async_so", signal_out, 0);
        check("async_day", day, 1);
        #10;
        rst_n = 1'b1;
        man(1'b1, 1'b0);
        man(1'b1, 1'b0);
        check("pre_rst_day", day, 3);
        rst_n = 1'b0;
        #2;
        check("async_day3", day, 1);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/day_counter.md
Name: day_counter

Overview:
Day-of-month counter for the calendar chain, directly upstream of the month counter.
- Advances on the 1-cycle day-carry pulse from the hour counter.
- Wraps at the month-specific length, using full Gregorian leap rules.
- Emits a 1-cycle carry pulse on signal_out that drives the month counter's signal input.
- Supports manual up/down setting. Clamps the day when the month or year changes under it.

Parameters:
YEAR_W, 14, width of the year input (0..9999 range used by the clock).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
up  input  1  manual increment request, level sampled each clk while manual_set=1
down  input  1  manual decrement request, level sampled each clk while manual_set=1
signal  input  1  day-carry pulse from the hour counter (1 cycle wide)
manual_set  input  1  manual-set mode enable
month  input  4  current month from the month counter, 1..12
year  input  YEAR_W  current year from the year counter
day  output  5  current day of month, 1..31, registered
signal_out  output  1  month-carry pulse, registered, 1 cycle wide

Behaviour:
- Reset (rst_n low, asynchronous): day=1, signal_out=0. Outputs hold these values until the first clk edge after release.
- max_day is combinational from month and year:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - Month 2: 29 if leap, else 28.
  - Illegal month (0, 13-15): 31.
- Leap year: (year mod 4 == 0) and ((year mod 100 != 0) or (year mod 400 == 0)). Year 0 is leap; 1900 is not; 2000 is; 2100 is not.
- Default each edge: signal_out <= 0 (pulse is never stretched).
- Priority per edge, highest first:
  1. manual_set=1 and up=1: day <= (day >= max_day) ? 1 : day+1. down is ignored.
  2. manual_set=1 and down=1: day <= (day <= 1) ? max_day : (day > max_day ? max_day : day-1).
  3. manual_set=1, neither up nor down: hold, except the clamp rule below.
  4. manual_set=0 and signal=1: if day >= max_day, then day <= 1 and signal_out <= 1. Else day <= day+1.
  5. Otherwise: hold, except the clamp rule.
- Clamp rule: in cases 3 and 5, if day > max_day (the month or year changed), day <= max_day on the next edge. No carry is generated.
- Manual mode never generates signal_out. signal is ignored while manual_set=1; missed carries are dropped, not queued.
- Latency: signal at edge N, then day and signal_out update at edge N. The month counter sees signal_out at edge N+1 and increments then. In the interval between, day=1, which is valid for any month, so the clamp rule cannot fire.
- day is never 0 and never exceeds 31, including in the illegal-month case.
- Reset mid-pulse: signal_out drops immediately and asynchronously, and day returns to 1.
- Arithmetic: day is a 5-bit unsigned value. Comparisons are unsigned against a 5-bit max_day. No overflow is possible because day+1 is only taken when day < max_day <= 31.

Decomposition:
- Shared package clock_cal_pkg:
  - Constants MONTH_FEB=2, DAY_MIN=1, DAY_W=5, YEAR_W default.
  - A function or constants for the 30-day month set.
- One combinational sub-module, month_length: inputs month and year, output max_day [4:0]. It contains the leap-year logic and the month table, and is reused by the calendar display/validation logic.
- day_counter holds only the register and priority logic.

Test Plan:
- Reset then release, with month=1, year=2024, no inputs -> day=1, signal_out=0. Both hold for 10 cycles.
- month=1, year=2023, day=31, one signal pulse -> after the edge, day=1 and signal_out=1 for exactly one cycle, then 0.
- Feb boundary, each case pulsed from day=28:
  - year=2024: pulse gives day=29, no carry; a second pulse gives day=1 with carry.
  - year=1900: pulse gives day=1 with carry.
  - year=2000: pulse gives day=29.
- Manual mode, month=4, day=1:
  - down=1 for one cycle -> day=30.
  - up=1 -> day=1.
  - up=1 and down=1 together -> day=2 (up wins).
  - signal pulses during manual mode -> no change, signal_out stays 0.
- Clamp: day=31 with month=1, then month changed to 2 with year=2023 and no other inputs -> next edge day=28, signal_out=0.
- Async reset asserted mid-cycle while signal_out=1 -> signal_out=0 and day=1 immediately, before the next clk edge.
